// File: rtl/instr_fetch_unit.sv
// Instruction fetch responder: turns a PC fetch address into a req/ack bus read,
// with a one-entry last-fetch buffer, misalignment trap and bus-timeout trap.
module instr_fetch_unit #(
  parameter int unsigned TIMEOUT = 255,
  parameter bit          BUF_EN  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_addr,
  input  logic        fetch_en,
  input  logic        flush,
  output logic        iready,
  output logic [31:0] instr,
  output logic        fetch_fault,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned CW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_RESP,
    S_FAULT
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [31:0]   r_instr;
  logic [31:0]   r_mem_addr;
  logic [CW-1:0] r_cnt;
  logic          r_buf_valid;
  logic [31:0]   r_buf_addr;
  logic [31:0]   r_buf_data;

  logic          w_misal;
  logic          w_hit;
  logic          w_timeout;

  assign w_misal   = (pc_addr[1:0] != 2'b00);
  // A flush in the same cycle must not be allowed to hit on the stale entry.
  assign w_hit     = BUF_EN && r_buf_valid && !flush && (pc_addr == r_buf_addr);
  assign w_timeout = (r_cnt == CW'(TIMEOUT - 1));

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (fetch_en) begin
          if (w_misal)    w_next = S_FAULT;
          else if (w_hit) w_next = S_RESP;
          else            w_next = S_REQ;
        end
      end
      S_REQ: begin
        if (mem_ack)        w_next = S_RESP;
        else if (w_timeout) w_next = S_FAULT;
      end
      S_RESP:  w_next = S_IDLE;
      S_FAULT: if (flush) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_instr     <= '0;
      r_mem_addr  <= '0;
      r_cnt       <= '0;
      r_buf_valid <= 1'b0;
      r_buf_addr  <= '0;
      r_buf_data  <= '0;
    end else begin
      if (flush) r_buf_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (fetch_en && !w_misal) begin
            if (w_hit) begin
              r_instr <= r_buf_data;
            end else begin
              r_mem_addr <= pc_addr;
              r_cnt      <= '0;
            end
          end
        end
        S_REQ: begin
          if (mem_ack) begin
            r_instr <= mem_rdata;
            if (BUF_EN && !flush) begin
              r_buf_addr  <= r_mem_addr;
              r_buf_data  <= mem_rdata;
              r_buf_valid <= 1'b1;
            end
          end else if (!w_timeout) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign iready      = (r_state == S_RESP);
  assign fetch_fault = (r_state == S_FAULT);
  assign mem_req     = (r_state == S_REQ);
  assign instr       = r_instr;
  assign mem_addr    = r_mem_addr;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed cases then randomized fetch
// transactions checked against a transaction-level model of the fetch buffer.
module tb_instr_fetch_unit;

  localparam int unsigned TO = 4;

  logic        clk;
  logic        rst;
  logic [31:0] pc_addr;
  logic        fetch_en;
  logic        flush;
  logic        iready;
  logic [31:0] instr;
  logic        fetch_fault;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  // Model of the last-fetch buffer contents.
  bit          m_valid = 1'b0;
  logic [31:0] m_addr  = '0;
  logic [31:0] m_data  = '0;

  instr_fetch_unit #(.TIMEOUT(TO), .BUF_EN(1'b1)) dut (
    .clk         (clk),
    .rst         (rst),
    .pc_addr     (pc_addr),
    .fetch_en    (fetch_en),
    .flush       (flush),
    .iready      (iready),
    .instr       (instr),
    .fetch_fault (fetch_fault),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired got=running exp=finished");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One fetch starting from IDLE at a negedge; returns at a negedge with the DUT idle.
  task automatic do_fetch(input logic [31:0] a, input int unsigned delay,
                          input bit idle_flush, input bit ack_flush, input logic [31:0] d);
    bit hit;
    int unsigned n;
    hit      = m_valid && (m_addr == a) && !idle_flush;
    pc_addr  = a;
    fetch_en = 1'b1;
    flush    = idle_flush;
    @(negedge clk);
    flush = 1'b0;
    if (idle_flush) m_valid = 1'b0;
    if (a[1:0] != 2'b00) begin
      fetch_en = 1'b0;
      check_eq("misal_fault", 32'(fetch_fault), 32'd1);
      check_eq("misal_iready", 32'(iready), 32'd0);
      check_eq("misal_req", 32'(mem_req), 32'd0);
      repeat (2) @(negedge clk);
      check_eq("misal_sticky", 32'(fetch_fault), 32'd1);
      flush = 1'b1;
      @(negedge clk);
      flush   = 1'b0;
      m_valid = 1'b0;
      check_eq("misal_clear", 32'(fetch_fault), 32'd0);
    end else if (hit) begin
      fetch_en = 1'b0;
      check_eq("hit_iready", 32'(iready), 32'd1);
      check_eq("hit_instr", instr, m_data);
      check_eq("hit_noreq", 32'(mem_req), 32'd0);
      @(negedge clk);
      check_eq("hit_iready_drop", 32'(iready), 32'd0);
      check_eq("hit_instr_hold", instr, m_data);
    end else begin
      n = (delay < TO) ? delay : TO;
      for (int unsigned k = 1; k <= n; k++) begin
        check_eq("req_active", 32'(mem_req), 32'd1);
        check_eq("req_addr", mem_addr, a);
        check_eq("req_iready", 32'(iready), 32'd0);
        fetch_en = 1'($urandom);
        if (k == delay) begin
          mem_ack   = 1'b1;
          mem_rdata = d;
          flush     = ack_flush;
          fetch_en  = 1'b0;
        end
        @(negedge clk);
        mem_ack   = 1'b0;
        flush     = 1'b0;
        mem_rdata = $urandom;
      end
      fetch_en = 1'b0;
      if (delay <= TO) begin
        check_eq("miss_iready", 32'(iready), 32'd1);
        check_eq("miss_instr", instr, d);
        check_eq("miss_req_drop", 32'(mem_req), 32'd0);
        if (ack_flush) begin
          m_valid = 1'b0;
        end else begin
          m_valid = 1'b1;
          m_addr  = a;
          m_data  = d;
        end
        @(negedge clk);
        check_eq("miss_iready_drop", 32'(iready), 32'd0);
        check_eq("miss_instr_hold", instr, d);
      end else begin
        check_eq("to_fault", 32'(fetch_fault), 32'd1);
        check_eq("to_req_drop", 32'(mem_req), 32'd0);
        check_eq("to_iready", 32'(iready), 32'd0);
        flush = 1'b1;
        @(negedge clk);
        flush   = 1'b0;
        m_valid = 1'b0;
        check_eq("to_clear", 32'(fetch_fault), 32'd0);
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_iready"}, 32'(iready), 32'd0);
    check_eq({tag, "_instr"}, instr, 32'd0);
    check_eq({tag, "_fault"}, 32'(fetch_fault), 32'd0);
    check_eq({tag, "_req"}, 32'(mem_req), 32'd0);
    check_eq({tag, "_addr"}, mem_addr, 32'd0);
  endtask

  initial begin
    logic [31:0] pool [4];
    logic [31:0] a;
    pool[0] = 32'h0000_0100;
    pool[1] = 32'h0000_0104;
    pool[2] = 32'h0000_2000;
    pool[3] = 32'hFFFF_FFFC;

    rst       = 1'b1;
    pc_addr   = '0;
    fetch_en  = 1'b0;
    flush     = 1'b0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    #1;
    check_reset_outputs("rst0");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    do_fetch(32'h0000_0100, 3, 1'b0, 1'b0, 32'h0010_0093);
    do_fetch(32'h0000_0100, 3, 1'b0, 1'b0, 32'hDEAD_0000);
    do_fetch(32'h0000_0100, 2, 1'b1, 1'b0, 32'h0010_0093);
    do_fetch(32'h0000_0104, 1, 1'b0, 1'b1, 32'h1234_5678);
    do_fetch(32'h0000_0104, 2, 1'b0, 1'b0, 32'h8765_4321);
    do_fetch(32'h0000_0104, 2, 1'b0, 1'b0, 32'h0);
    do_fetch(32'h0000_0102, 1, 1'b0, 1'b0, 32'h0);
    do_fetch(32'h0000_0104, 1, 1'b0, 1'b0, 32'h5555_AAAA);
    do_fetch(32'h0000_0300, TO + 5, 1'b0, 1'b0, 32'h0);

    // Asynchronous reset in the middle of a bus request.
    pc_addr  = 32'h0000_0200;
    fetch_en = 1'b1;
    @(negedge clk);
    fetch_en = 1'b0;
    check_eq("pre_rst_req", 32'(mem_req), 32'd1);
    #2 rst = 1'b1;
    #1;
    check_reset_outputs("rst_mid");
    @(negedge clk);
    rst     = 1'b0;
    m_valid = 1'b0;
    @(negedge clk);
    do_fetch(32'h0000_0200, 2, 1'b0, 1'b0, 32'hCAFE_F00D);
    do_fetch(32'h0000_0200, 1, 1'b0, 1'b0, 32'h0);

    for (int i = 0; i < 150; i++) begin
      a = pool[$urandom_range(0, 3)];
      if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
      do_fetch(a, $urandom_range(1, TO + 1), ($urandom_range(0, 5) == 0),
               ($urandom_range(0, 5) == 0), $urandom);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
